// File: rtl/secuenciador_tipor.sv
// Purpose: issue controller for the R-type datapath; buffers instructions, decodes funct, inserts bubbles.
// Latency: instruction pushed at edge N into an empty FIFO while idle is popped at N+1 and driven after it.
// Backpressure: in_ready = !full; upstream holds in_valid/in_instr until accepted, pops only on ISSUE entry.
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   en                    gates new pops; a running ISSUE/BUBBLE sequence always completes
//   in_valid/in_instr     upstream instruction, accepted when in_ready is high
//   in_ready              FIFO not full
//   instruccion           instruction driven to the datapath (0 outside legal ISSUE slots)
//   reg_we, alu_ctl       decoded write enable / ALU control for the current slot
//   ZF_DPTR, zf_q         datapath zero flag in, flag captured at the end of each legal ISSUE
//   err                   sticky illegal-instruction flag
//   busy                  FSM not idle or FIFO not empty
//   issued                wrapping count of legal instructions issued

// Purpose: small generic synchronous FIFO with first-word fall-through head.
// Latency: a pushed word is visible on head_dat the cycle after the push edge.
// Backpressure: caller must not push when full nor pop when empty.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at AW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_vld, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module secuenciador_tipor #(
    parameter int DEPTH   = 4,
    parameter int BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic [31:0] instruccion,
    output logic        reg_we,
    output logic [2:0]  alu_ctl,
    input  logic        ZF_DPTR,
    output logic        zf_q,
    output logic        err,
    output logic        busy,
    output logic [15:0] issued
);
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Reload value for the bubble counter; unused when BUBBLES is 0.
    localparam int unsigned BUB_M1 = (BUBBLES > 0) ? BUBBLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_BUBBLE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  bub_cnt;
    logic        slot_ill;   // current ISSUE slot carries an illegal instruction

    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] head_dat;
    logic        push;
    logic        pop_go;

    logic        dec_ok;
    logic        dec_we;
    logic [2:0]  dec_alu;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign busy     = (state != S_IDLE) || !fifo_empty;

    sync_fifo #(
        .W     (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push),
        .push_dat (in_instr),
        .pop      (pop_go),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Every path into ISSUE is a pop; en only gates the decision points.
    always_comb begin
        pop_go = 1'b0;
        case (state)
            S_IDLE:   pop_go = en && !fifo_empty;
            S_ISSUE:  pop_go = (BUBBLES == 0) && en && !fifo_empty;
            S_BUBBLE: pop_go = (bub_cnt == 3'd0) && en && !fifo_empty;
            default:  pop_go = 1'b0;
        endcase
    end

    // Decode of the FIFO head, used on the edge that pops it. The all-zero
    // word is a legal NOP; everything else needs opcode 0 and a known funct.
    always_comb begin
        dec_ok  = 1'b0;
        dec_we  = 1'b0;
        dec_alu = ALU_ADD;
        if (head_dat == 32'd0) begin
            dec_ok = 1'b1;
        end else if (head_dat[31:26] == 6'd0) begin
            case (head_dat[5:0])
                6'b100000: begin dec_ok = 1'b1; dec_we = 1'b1; dec_alu = ALU_ADD; end
                6'b100010: begin dec_ok = 1'b1; dec_we = 1'b1; dec_alu = ALU_SUB; end
                6'b100100: begin dec_ok = 1'b1; dec_we = 1'b1; dec_alu = ALU_AND; end
                6'b100101: begin dec_ok = 1'b1; dec_we = 1'b1; dec_alu = ALU_OR;  end
                6'b101010: begin dec_ok = 1'b1; dec_we = 1'b1; dec_alu = ALU_SLT; end
                default:   begin dec_ok = 1'b0; dec_we = 1'b0; dec_alu = ALU_ADD; end
            endcase
        end
    end

    // FSM with registered slot outputs: the slot contents are loaded on the
    // pop edge so they are stable for the whole ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            bub_cnt     <= 3'd0;
            slot_ill    <= 1'b0;
            instruccion <= 32'd0;
            reg_we      <= 1'b0;
            alu_ctl     <= ALU_ADD;
            zf_q        <= 1'b0;
            err         <= 1'b0;
            issued      <= 16'd0;
        end else begin
            // Bookkeeping on the edge that closes a legal ISSUE slot.
            if (state == S_ISSUE && !slot_ill) begin
                zf_q   <= ZF_DPTR;
                issued <= issued + 16'd1;
            end

            if (pop_go) begin
                state    <= S_ISSUE;
                slot_ill <= !dec_ok;
                if (dec_ok) begin
                    instruccion <= head_dat;
                    reg_we      <= dec_we;
                    alu_ctl     <= dec_alu;
                end else begin
                    instruccion <= 32'd0;
                    reg_we      <= 1'b0;
                    alu_ctl     <= ALU_ADD;
                    err         <= 1'b1;
                end
            end else begin
                slot_ill    <= 1'b0;
                instruccion <= 32'd0;
                reg_we      <= 1'b0;
                alu_ctl     <= ALU_ADD;
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_ISSUE: begin
                        if (BUBBLES > 0) begin
                            state   <= S_BUBBLE;
                            bub_cnt <= 3'(BUB_M1);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_BUBBLE: begin
                        if (bub_cnt == 3'd0) begin
                            state <= S_IDLE;
                        end else begin
                            bub_cnt <= bub_cnt - 3'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
